usb_packet_serializer: RTL and testbench
========================================

Name: usb_packet_serializer

Overview:
- Parametrised, next-generation USB packet bit serializer.
- Accepts one packet description per handshake and emits SYNC, PID/~PID, the packet-class fields and the generated CRC, one bit per unpaused clock, LSB first.
- Handles token, data (variable length, up to MAX_BYTES) and handshake packets.
- Feeds the downstream NRZI/bit-stuff stage, which throttles it through pause.

Parameters:
- MAX_BYTES, 8, maximum data-packet payload in bytes (1..1024).
- LEN_W, $clog2(MAX_BYTES+1), width of the nbytes field.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- pktready  input  1  upstream holds high while a packet description is valid.
- pause  input  1  downstream stall; freezes bit position, outb and CRC.
- pid  input  4  packet ID; pid[1:0] selects class: 01 token, 11 data, 10/00 handshake (PID only).
- addr  input  7  token device address.
- endp  input  4  token endpoint.
- data  input  8*MAX_BYTES  payload; byte k = data[8k+7:8k]; byte 0 is sent first.
- nbytes  input  LEN_W  payload length; values above MAX_BYTES are clamped to MAX_BYTES.
- outb  output  1  current serial bit.
- sending  output  1  high while outb carries a packet bit.
- gotpkt  output  1  one-cycle pulse: description captured.
- pktdone  output  1  one-cycle pulse: last bit consumed.

Behaviour:
- Reset values: state IDLE; outb=0, sending=0, gotpkt=0, pktdone=0; CRC registers and counters cleared.
  - Reset mid-packet aborts the packet. Outputs take reset values on the next cycle.
  - No pktdone is issued for an aborted packet.
- States: IDLE -> SYNC -> PID -> (TOKEN | DATA | CRC) -> CRC -> IDLE.
  - Handshake class goes PID -> IDLE directly, with no CRC state.
- IDLE: if pktready=1 at an edge, all inputs are captured into internal registers.
  - gotpkt=1 during the following cycle only.
  - State becomes SYNC and sending=1 in that same cycle.
  - pktready is ignored whenever state is not IDLE.
- Bit advance: in every non-IDLE state, at each edge with pause=0 the bit index advances. With pause=1, outb, the index and the CRC all hold.
  - pause during IDLE has no effect.
- SYNC: 8 bits 0,0,0,0,0,0,0,1.
- PID: pid[0..3], then ~pid[0..3].
- TOKEN: addr[0..6], then endp[0..3] (11 bits, fed into CRC5).
  - CRC5: polynomial x^5+x^2+1, initial value 11111.
  - The complemented remainder is sent as 5 bits, remainder MSB first.
- DATA: nbytes bytes, each LSB first, fed into CRC16.
  - CRC16: polynomial 0x8005, initial value 0xFFFF.
  - The complemented remainder is sent as 16 bits, MSB first.
  - nbytes=0 (after clamp) skips DATA entirely and goes to CRC; the CRC field is then 16 zeros.
- Packet lengths in bit-cycles, excluding pauses:
  - token 32;
  - data 32+8*N;
  - handshake 16.
- Completion: when the last bit is consumed (pause=0 at that edge), pktdone=1 for one cycle and sending=0 in the same cycle; state is IDLE.
  - A new pktready is accepted in that same IDLE cycle, so back-to-back packets have a 1-cycle gap.
- outb is 0 whenever sending=0.
- Byte and bit counters saturate at their final value and never wrap. The CRC counter is LEN_W+3 bits wide.

Decomposition:
- Package usb_ser_pkg holds:
  - enum pkt_class_t {HANDSHAKE, TOKEN, DATA};
  - enum state_t;
  - SYNC_PATTERN=8'h80;
  - CRC5_POLY, CRC5_INIT, CRC16_POLY, CRC16_INIT.
- One sub-module, usb_crc_serial, parametrised by WIDTH/POLY/INIT:
  - ports clk, rst, clr, en, din, crc_out_bit, shift_out;
  - instantiated twice (CRC5, CRC16).

Test Plan:
- SETUP token (pid=4'b1101, addr=0, endp=0, no pause) -> 32 sending cycles.
  - Wire stream: SYNC, then 1,0,1,1,0,1,0,0, then 11 zeros, then CRC bits 0,1,0,0,0 (field 0x02).
  - gotpkt 1 cycle after accept; pktdone on cycle 33.
- ACK handshake (pid=4'b0010) -> 16 bits: SYNC, then 0,1,0,0,1,0,1,1; no CRC; pktdone at cycle 17.
- DATA0 (pid=4'b0011), nbytes=0 -> 32 bits, last 16 all 0.
- DATA1, nbytes=4, data=32'h03020100 -> 64 bits; payload bits match byte order 00,01,02,03 LSB first.
  - CRC16 field matches the bench reference model.
- Same DATA1 packet with pause asserted for 3 cycles at bit 20 and bit 63 -> identical bit sequence; outb held during pauses; pktdone delayed by exactly 6 cycles.
- Boundary cases:
  - rst asserted at bit 40 of a data packet -> next cycle sending=0, outb=0, no pktdone.
  - pktready held high through completion -> second packet accepted in the pktdone cycle.
  - nbytes=MAX_BYTES+3 -> clamped to MAX_BYTES bytes.

Source files
------------

// File: rtl/usb_ser_pkg.sv
// Shared types, constants and bit-selection helpers for the USB packet serializer.
package usb_ser_pkg;

    typedef enum logic [1:0] {
        HANDSHAKE = 2'd0,
        TOKEN     = 2'd1,
        DATA      = 2'd2
    } pkt_class_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_PID   = 3'd2,
        ST_TOKEN = 3'd3,
        ST_DATA  = 3'd4,
        ST_CRC   = 3'd5
    } state_t;

    localparam logic [7:0]  SYNC_PATTERN = 8'h80;
    localparam logic [4:0]  CRC5_POLY    = 5'h05;
    localparam logic [4:0]  CRC5_INIT    = 5'h1F;
    localparam logic [15:0] CRC16_POLY   = 16'h8005;
    localparam logic [15:0] CRC16_INIT   = 16'hFFFF;

    // Packet class is encoded in the two low PID bits.
    function automatic pkt_class_t pid_class(input logic [3:0] pid);
        pkt_class_t cls;
        case (pid[1:0])
            2'b01:   cls = TOKEN;
            2'b11:   cls = DATA;
            default: cls = HANDSHAKE;
        endcase
        return cls;
    endfunction

    // Bit idx of the SYNC field, sent LSB first.
    function automatic logic sync_bit(input logic [2:0] idx);
        return SYNC_PATTERN[idx];
    endfunction

    // Bit idx of the PID field: pid[0..3] then ~pid[0..3].
    function automatic logic pid_bit(input logic [3:0] pid, input logic [2:0] idx);
        logic [7:0] fld;
        fld = {~pid, pid};
        return fld[idx];
    endfunction

    // Bit idx of the token field: addr[0..6] then endp[0..3].
    function automatic logic token_bit(input logic [6:0] addr, input logic [3:0] endp,
                                       input logic [3:0] idx);
        logic [15:0] fld;
        fld = {5'b00000, endp, addr};
        return fld[idx];
    endfunction

endpackage

// File: rtl/usb_crc_serial.sv
// Serial MSB-first CRC generator. While shift_out=0 each enabled cycle folds din
// into the remainder; while shift_out=1 each enabled cycle shifts the remainder
// out, and crc_out_bit presents the complemented MSB that goes on the wire.
module usb_crc_serial #(
    parameter int               WIDTH = 5,
    parameter logic [WIDTH-1:0] POLY  = '0,
    parameter logic [WIDTH-1:0] INIT  = '1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic din,
    input  logic shift_out,
    output logic crc_out_bit
);

    logic [WIDTH-1:0] crc_r;
    logic             fb_s;

    assign fb_s        = crc_r[WIDTH-1] ^ din;
    assign crc_out_bit = ~crc_r[WIDTH-1];

    // Remainder register: preset on clr, LFSR step or plain shift when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_r <= '0;
        end else if (clr) begin
            crc_r <= INIT;
        end else if (en) begin
            if (shift_out) begin
                crc_r <= {crc_r[WIDTH-2:0], 1'b0};
            end else begin
                crc_r <= {crc_r[WIDTH-2:0], 1'b0} ^ (fb_s ? POLY : {WIDTH{1'b0}});
            end
        end else begin
            crc_r <= crc_r;
        end
    end

endmodule

// File: rtl/usb_packet_serializer.sv
// USB packet bit serializer: SYNC, PID/~PID, token or data fields and CRC,
// one bit per unpaused clock, LSB first. outb always holds the bit currently
// on the wire; the combinational block picks the bit loaded at the next advance.
module usb_packet_serializer
    import usb_ser_pkg::*;
#(
    parameter int MAX_BYTES = 8,
    parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pktready,
    input  logic                   pause,
    input  logic [3:0]             pid,
    input  logic [6:0]             addr,
    input  logic [3:0]             endp,
    input  logic [8*MAX_BYTES-1:0] data,
    input  logic [LEN_W-1:0]       nbytes,
    output logic                   outb,
    output logic                   sending,
    output logic                   gotpkt,
    output logic                   pktdone
);

    localparam int CW = LEN_W + 3;
    localparam int DW = 8 * MAX_BYTES;
    localparam int IW = $clog2(DW);

    state_t           state_r;
    pkt_class_t       cls_r;
    logic [CW-1:0]    cnt_r;
    logic [3:0]       pid_r;
    logic [6:0]       addr_r;
    logic [3:0]       endp_r;
    logic [DW-1:0]    data_r;
    logic [LEN_W-1:0] nbytes_r;
    logic             outb_r, sending_r, gotpkt_r, pktdone_r;

    state_t           nxt_state_s;
    logic [CW-1:0]    nxt_cnt_s, cnt_inc_s, data_last_s, crc_last_s;
    logic [LEN_W-1:0] nbytes_clamp_s;
    logic             nxt_bit_s, last_s, crc_din_s;
    logic             c5_en_s, c5_sh_s, c16_en_s, c16_sh_s;
    logic             crc5_bit_s, crc16_bit_s, accept_s, adv_s;

    assign accept_s       = (state_r == ST_IDLE) & pktready;
    assign adv_s          = (state_r != ST_IDLE) & ~pause;
    assign cnt_inc_s      = cnt_r + CW'(1);
    assign data_last_s    = {nbytes_r, 3'b000} - CW'(1);
    assign crc_last_s     = (cls_r == TOKEN) ? CW'(4) : CW'(15);
    assign nbytes_clamp_s = (nbytes > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : nbytes;

    usb_crc_serial #(.WIDTH(5), .POLY(CRC5_POLY), .INIT(CRC5_INIT)) u_crc5 (
        .clk(clk), .rst(rst), .clr(accept_s), .en(adv_s & c5_en_s),
        .din(crc_din_s), .shift_out(c5_sh_s), .crc_out_bit(crc5_bit_s)
    );

    usb_crc_serial #(.WIDTH(16), .POLY(CRC16_POLY), .INIT(CRC16_INIT)) u_crc16 (
        .clk(clk), .rst(rst), .clr(accept_s), .en(adv_s & c16_en_s),
        .din(crc_din_s), .shift_out(c16_sh_s), .crc_out_bit(crc16_bit_s)
    );

    // Choose the next field position and the bit loaded onto outb at the next advance;
    // field bits enter the CRC as they are loaded so the remainder is ready for the CRC field.
    always_comb begin
        nxt_state_s = state_r;
        nxt_cnt_s   = cnt_inc_s;
        nxt_bit_s   = 1'b0;
        last_s      = 1'b0;
        crc_din_s   = 1'b0;
        c5_en_s     = 1'b0;
        c5_sh_s     = 1'b0;
        c16_en_s    = 1'b0;
        c16_sh_s    = 1'b0;
        case (state_r)
            ST_SYNC: begin
                if (cnt_r == CW'(7)) begin
                    nxt_state_s = ST_PID;
                    nxt_cnt_s   = CW'(0);
                    nxt_bit_s   = pid_r[0];
                end else begin
                    nxt_bit_s = sync_bit(cnt_inc_s[2:0]);
                end
            end
            ST_PID: begin
                if (cnt_r == CW'(7)) begin
                    nxt_cnt_s = CW'(0);
                    case (cls_r)
                        TOKEN: begin
                            nxt_state_s = ST_TOKEN;
                            nxt_bit_s   = addr_r[0];
                            crc_din_s   = addr_r[0];
                            c5_en_s     = 1'b1;
                        end
                        DATA: begin
                            c16_en_s = 1'b1;
                            if (nbytes_r == LEN_W'(0)) begin
                                nxt_state_s = ST_CRC;
                                nxt_bit_s   = crc16_bit_s;
                                c16_sh_s    = 1'b1;
                            end else begin
                                nxt_state_s = ST_DATA;
                                nxt_bit_s   = data_r[0];
                                crc_din_s   = data_r[0];
                            end
                        end
                        default: begin
                            nxt_state_s = ST_IDLE;
                            last_s      = 1'b1;
                        end
                    endcase
                end else begin
                    nxt_bit_s = pid_bit(pid_r, cnt_inc_s[2:0]);
                end
            end
            ST_TOKEN: begin
                c5_en_s = 1'b1;
                if (cnt_r == CW'(10)) begin
                    nxt_state_s = ST_CRC;
                    nxt_cnt_s   = CW'(0);
                    nxt_bit_s   = crc5_bit_s;
                    c5_sh_s     = 1'b1;
                end else begin
                    nxt_bit_s = token_bit(addr_r, endp_r, cnt_inc_s[3:0]);
                    crc_din_s = nxt_bit_s;
                end
            end
            ST_DATA: begin
                c16_en_s = 1'b1;
                if (cnt_r == data_last_s) begin
                    nxt_state_s = ST_CRC;
                    nxt_cnt_s   = CW'(0);
                    nxt_bit_s   = crc16_bit_s;
                    c16_sh_s    = 1'b1;
                end else begin
                    nxt_bit_s = data_r[cnt_inc_s[IW-1:0]];
                    crc_din_s = nxt_bit_s;
                end
            end
            ST_CRC: begin
                if (cnt_r == crc_last_s) begin
                    nxt_state_s = ST_IDLE;
                    nxt_cnt_s   = CW'(0);
                    last_s      = 1'b1;
                end else if (cls_r == TOKEN) begin
                    nxt_bit_s = crc5_bit_s;
                    c5_en_s   = 1'b1;
                    c5_sh_s   = 1'b1;
                end else begin
                    nxt_bit_s = crc16_bit_s;
                    c16_en_s  = 1'b1;
                    c16_sh_s  = 1'b1;
                end
            end
            default: begin
                nxt_state_s = ST_IDLE;
                nxt_cnt_s   = CW'(0);
            end
        endcase
    end

    // Packet capture, bit advance under pause, and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cls_r     <= HANDSHAKE;
            cnt_r     <= '0;
            pid_r     <= 4'h0;
            addr_r    <= 7'h00;
            endp_r    <= 4'h0;
            data_r    <= '0;
            nbytes_r  <= '0;
            outb_r    <= 1'b0;
            sending_r <= 1'b0;
            gotpkt_r  <= 1'b0;
            pktdone_r <= 1'b0;
        end else begin
            gotpkt_r  <= 1'b0;
            pktdone_r <= 1'b0;
            if (state_r == ST_IDLE) begin
                if (pktready) begin
                    state_r   <= ST_SYNC;
                    cls_r     <= pid_class(pid);
                    cnt_r     <= '0;
                    pid_r     <= pid;
                    addr_r    <= addr;
                    endp_r    <= endp;
                    data_r    <= data;
                    nbytes_r  <= nbytes_clamp_s;
                    outb_r    <= sync_bit(3'd0);
                    sending_r <= 1'b1;
                    gotpkt_r  <= 1'b1;
                end else begin
                    outb_r    <= 1'b0;
                    sending_r <= 1'b0;
                end
            end else if (!pause) begin
                state_r   <= nxt_state_s;
                cnt_r     <= nxt_cnt_s;
                outb_r    <= nxt_bit_s;
                sending_r <= ~last_s;
                pktdone_r <= last_s;
            end else begin
                state_r <= state_r;
                cnt_r   <= cnt_r;
                outb_r  <= outb_r;
            end
        end
    end

    assign outb    = outb_r;
    assign sending = sending_r;
    assign gotpkt  = gotpkt_r;
    assign pktdone = pktdone_r;

endmodule

// File: tb/tb_usb_packet_serializer.sv
// Directed bench for usb_packet_serializer: captures the serial stream of each
// packet and compares it, plus pulse timing, against hand-built expectations.
module tb_usb_packet_serializer;

    localparam int MAX_BYTES = 8;
    localparam int LEN_W     = 4;

    logic                   clk = 1'b0;
    logic                   rst, pktready, pause;
    logic [3:0]             pid, endp;
    logic [6:0]             addr;
    logic [8*MAX_BYTES-1:0] data;
    logic [LEN_W-1:0]       nbytes;
    logic                   outb, sending, gotpkt, pktdone;

    int n_checks = 0;
    int n_errors = 0;

    usb_packet_serializer #(.MAX_BYTES(MAX_BYTES), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .pktready(pktready), .pause(pause),
        .pid(pid), .addr(addr), .endp(endp), .data(data), .nbytes(nbytes),
        .outb(outb), .sending(sending), .gotpkt(gotpkt), .pktdone(pktdone)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reflected-form reference CRC16; returns the field in wire order (bit 0 sent first).
    function automatic logic [15:0] crc16_field(input logic [63:0] d, input int nb);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < nb * 8; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ 16'hA001;
            else             c = c >> 1;
        end
        return ~c;
    endfunction

    // Send one packet, record its bits, optionally pause 3 cycles at bit pa0/pa1.
    task automatic send_pkt(input string tag, input logic [3:0] p, input logic [6:0] a,
                            input logic [3:0] e, input logic [63:0] d, input logic [3:0] n,
                            input logic [127:0] exp_bits, input int len, input int pa0, input int pa1);
        logic [127:0] got;
        int bi, cyc, done_cyc, hold_err, npause;
        logic done, held;
        got = '0; bi = 0; cyc = 0; done_cyc = 0; hold_err = 0; done = 1'b0;
        npause = ((pa0 >= 0) ? 1 : 0) + ((pa1 >= 0) ? 1 : 0);
        pid = p; addr = a; endp = e; data = d; nbytes = n; pause = 1'b0;
        pktready = 1'b1;
        step(); cyc = 1;
        pktready = 1'b0;
        check_eq({tag, "_gotpkt"}, {126'b0, gotpkt, sending}, 128'd3);
        for (int guard = 0; guard < 400 && !done; guard++) begin
            if (pktdone) begin
                done = 1'b1;
                done_cyc = cyc;
                check_eq({tag, "_idle_at_done"}, {126'b0, sending, outb}, 128'd0);
            end else begin
                if (bi < 128) got[bi] = outb;
                if (bi == pa0 || bi == pa1) begin
                    held = outb;
                    pause = 1'b1;
                    repeat (3) begin
                        step(); cyc++;
                        if (outb !== held || sending !== 1'b1) hold_err++;
                    end
                    pause = 1'b0;
                end
                bi++;
                step(); cyc++;
            end
        end
        check_eq({tag, "_done_seen"}, {127'b0, done}, 128'd1);
        check_eq({tag, "_nbits"}, 128'(bi), 128'(len));
        check_eq({tag, "_done_cycle"}, 128'(done_cyc), 128'(len + 1 + 3 * npause));
        check_eq({tag, "_bits"}, got, exp_bits);
        if (npause > 0) check_eq({tag, "_hold"}, 128'(hold_err), 128'd0);
        step();
        check_eq({tag, "_done_pulse"}, {127'b0, pktdone}, 128'd0);
    endtask

    initial begin
        logic [63:0]  d4, d8;
        logic [15:0]  c4, c8;
        logic         flag;
        int           bi;

        rst = 1'b1; pktready = 1'b0; pause = 1'b0;
        pid = 4'h0; addr = 7'h00; endp = 4'h0; data = '0; nbytes = 4'd0;
        repeat (3) step();
        check_eq("reset_outputs", {124'b0, outb, sending, gotpkt, pktdone}, 128'd0);
        rst = 1'b0;
        pause = 1'b1;
        step();
        check_eq("idle_pause_quiet", {126'b0, sending, outb}, 128'd0);
        pause = 1'b0;

        // SETUP token, addr 0 endp 0: CRC5 field 0,1,0,0,0 on the wire
        send_pkt("setup", 4'b1101, 7'h00, 4'h0, 64'h0, 4'd0, 128'h10002D80, 32, -1, -1);
        // ACK handshake
        send_pkt("ack", 4'b0010, 7'h00, 4'h0, 64'h0, 4'd0, 128'h0000D280, 16, -1, -1);
        // DATA0 with no payload: 16 zero CRC bits
        send_pkt("data0_empty", 4'b0011, 7'h00, 4'h0, 64'h0, 4'd0, 128'h0000C380, 32, -1, -1);

        d4 = 64'h0000_0000_0302_0100;
        c4 = crc16_field(d4, 4);
        send_pkt("data1_4b", 4'b1011, 7'h00, 4'h0, d4, 4'd4,
                 {64'b0, c4, 32'h03020100, 16'h4B80}, 64, -1, -1);
        send_pkt("data1_pause", 4'b1011, 7'h00, 4'h0, d4, 4'd4,
                 {64'b0, c4, 32'h03020100, 16'h4B80}, 64, 20, 63);

        // Reset at bit 40 of a data packet aborts it without pktdone
        pid = 4'b1011; data = d4; nbytes = 4'd4; pktready = 1'b1;
        step();
        pktready = 1'b0;
        bi = 0;
        while (bi < 40) begin step(); bi++; end
        check_eq("abort_pre_sending", {127'b0, sending}, 128'd1);
        rst = 1'b1;
        step();
        check_eq("abort_outputs", {125'b0, sending, outb, pktdone}, 128'd0);
        rst = 1'b0;
        flag = 1'b0;
        repeat (80) begin
            step();
            if (pktdone || sending) flag = 1'b1;
        end
        check_eq("abort_no_done", {127'b0, flag}, 128'd0);

        // pktready held through completion: next packet taken in the pktdone cycle
        pid = 4'b0010; pktready = 1'b1;
        step();
        flag = 1'b0;
        for (int g = 0; g < 40 && !flag; g++) begin
            step();
            if (pktdone) flag = 1'b1;
        end
        check_eq("b2b_first_done", {127'b0, flag}, 128'd1);
        step();
        check_eq("b2b_second_accept", {126'b0, gotpkt, sending}, 128'd3);
        pktready = 1'b0;
        repeat (16) step();
        check_eq("b2b_second_done", {127'b0, pktdone}, 128'd1);
        step();

        // nbytes beyond MAX_BYTES is clamped to MAX_BYTES
        d8 = 64'hF0E1_D2C3_B4A5_9687;
        c8 = crc16_field(d8, 8);
        send_pkt("clamp", 4'b0011, 7'h00, 4'h0, d8, 4'd11,
                 {32'b0, c8, d8, 16'hC380}, 96, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
